// File: rtl/transposed_fir_pkg.sv
// Shared defaults for the transposed-form FIR: sizes, default coefficients
// and the fill-counter type used by the control logic.
package transposed_fir_pkg;

    localparam int P_FIR_ORDER     = 4;
    localparam int P_SAMPLE_SIZE   = 6;
    localparam int P_WEIGHT_SIZE   = 5;
    localparam int P_WORD_SIZE_OUT = 2 * P_SAMPLE_SIZE + 3;

    // Coefficient storage is sized for this many taps; FIR_order must stay below it.
    localparam int MAX_TAPS = 5;

    localparam logic [P_WEIGHT_SIZE-1:0] P_B0 = 5'd3;
    localparam logic [P_WEIGHT_SIZE-1:0] P_B1 = 5'd7;
    localparam logic [P_WEIGHT_SIZE-1:0] P_B2 = 5'd20;
    localparam logic [P_WEIGHT_SIZE-1:0] P_B3 = 5'd7;
    localparam logic [P_WEIGHT_SIZE-1:0] P_B4 = 5'd3;

    typedef logic [2:0] fill_cnt_t;

    function automatic fill_cnt_t fill_limit(input int fir_order);
        return fill_cnt_t'(fir_order + 1);
    endfunction

endpackage

// File: rtl/transposed_fir_if.sv
// Sample-in / result-out bundle of the transposed FIR.
interface transposed_fir_if
    import transposed_fir_pkg::*;
#(
    parameter int Sample_size   = P_SAMPLE_SIZE,
    parameter int word_size_out = P_WORD_SIZE_OUT
);
    logic [Sample_size-1:0]   Sample_in;
    logic                     sample_valid;
    logic [word_size_out-1:0] FIR_out;
    logic                     out_valid;
    logic                     filled;

    modport master (
        output Sample_in,
        output sample_valid,
        input  FIR_out,
        input  out_valid,
        input  filled
    );

    modport slave (
        input  Sample_in,
        input  sample_valid,
        output FIR_out,
        output out_valid,
        output filled
    );
endinterface

// File: rtl/fir_tap.sv
// One transposed-form tap: registered product of the current sample and a
// partial-sum register fed by the next tap up the chain.
module fir_tap
    import transposed_fir_pkg::*;
#(
    parameter int                     Sample_size   = P_SAMPLE_SIZE,
    parameter int                     weight_size   = P_WEIGHT_SIZE,
    parameter int                     word_size_out = P_WORD_SIZE_OUT,
    parameter logic [weight_size-1:0] coeff         = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     sample_valid,
    input  logic                     prod_valid,
    input  logic [Sample_size-1:0]   sample_in,
    input  logic [word_size_out-1:0] sum_in,
    output logic [word_size_out-1:0] sum_out
);
    localparam int PROD_W = Sample_size + weight_size;

    logic [PROD_W-1:0] prod;

    // Both registers hold while their stage is idle, so input gaps never
    // inject zero samples into the chain.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prod    <= '0;
            sum_out <= '0;
        end else begin
            if (sample_valid)
                prod <= PROD_W'(sample_in) * PROD_W'(coeff);
            if (prod_valid)
                sum_out <= word_size_out'(prod) + sum_in;
        end
    end
endmodule

// File: rtl/transposed_fir.sv
// Transposed direct-form FIR: every tap multiplies the newest accepted sample,
// delays live in the adder chain, results emerge two edges after acceptance.
module transposed_fir
    import transposed_fir_pkg::*;
#(
    parameter int                     FIR_order     = P_FIR_ORDER,
    parameter int                     Sample_size   = P_SAMPLE_SIZE,
    parameter int                     weight_size   = P_WEIGHT_SIZE,
    parameter int                     word_size_out = 2 * Sample_size + 3,
    parameter logic [weight_size-1:0] b0            = weight_size'(P_B0),
    parameter logic [weight_size-1:0] b1            = weight_size'(P_B1),
    parameter logic [weight_size-1:0] b2            = weight_size'(P_B2),
    parameter logic [weight_size-1:0] b3            = weight_size'(P_B3),
    parameter logic [weight_size-1:0] b4            = weight_size'(P_B4)
) (
    input  logic             clock,
    input  logic             reset,
    transposed_fir_if.slave  bus
);
    localparam int                     TAPS     = FIR_order + 1;
    localparam fill_cnt_t              FILL_MAX = fill_limit(FIR_order);
    localparam logic [weight_size-1:0] COEF [MAX_TAPS] = '{b0, b1, b2, b3, b4};

    logic                     prod_valid;
    logic                     out_valid;
    logic                     filled;
    fill_cnt_t                fill_cnt;
    logic [word_size_out-1:0] sum [0:TAPS];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prod_valid <= 1'b0;
            out_valid  <= 1'b0;
            fill_cnt   <= '0;
            filled     <= 1'b0;
        end else begin
            prod_valid <= bus.sample_valid;
            out_valid  <= prod_valid;
            if (bus.sample_valid && (fill_cnt != FILL_MAX)) begin
                fill_cnt <= fill_cnt + 3'd1;
                filled   <= ((fill_cnt + 3'd1) == FILL_MAX);
            end
        end
    end

    // The highest tap has no upstream partial sum; tap 0's register is the output.
    assign sum[TAPS] = '0;

    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        fir_tap #(
            .Sample_size  (Sample_size),
            .weight_size  (weight_size),
            .word_size_out(word_size_out),
            .coeff        (COEF[k])
        ) u_tap (
            .clock       (clock),
            .reset       (reset),
            .sample_valid(bus.sample_valid),
            .prod_valid  (prod_valid),
            .sample_in   (bus.Sample_in),
            .sum_in      (sum[k+1]),
            .sum_out     (sum[k])
        );
    end

    assign bus.FIR_out   = sum[0];
    assign bus.out_valid = out_valid;
    assign bus.filled    = filled;
endmodule

// File: tb/tb_transposed_fir.sv
// Self-checking bench for transposed_fir: directed impulse/step/gap/reset
// scenarios plus randomized gapped traffic against a convolution model.
module tb_transposed_fir;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    transposed_fir_if #(.Sample_size(6), .word_size_out(15)) bus ();

    transposed_fir dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: history of accepted samples, two-edge latency.
    int B [5] = '{3, 7, 20, 7, 3};
    int hist [$];
    logic d1_v = 1'b0;
    int d1_y = 0;
    logic exp_valid = 1'b0;
    int exp_out = 0;
    logic exp_filled = 1'b0;

    function automatic int y_ref();
        int acc = 0;
        int n = hist.size();
        for (int k = 0; k < 5; k++)
            if (n - 1 - k >= 0) acc += B[k] * hist[n - 1 - k];
        return acc;
    endfunction

    task automatic model_clear();
        hist.delete();
        d1_v = 1'b0;
        d1_y = 0;
        exp_valid = 1'b0;
        exp_out = 0;
        exp_filled = 1'b0;
    endtask

    task automatic cycle(input logic v, input logic [5:0] x);
        bus.sample_valid = v;
        bus.Sample_in = x;
        @(posedge clock);
        #1;
        exp_valid = d1_v;
        if (d1_v) exp_out = d1_y;
        d1_v = v;
        if (v) begin
            hist.push_back(int'(x));
            d1_y = y_ref();
        end
        exp_filled = (hist.size() >= 5);
    endtask

    task automatic assert_reset();
        #2;
        reset = 1'b0;
        bus.sample_valid = 1'b0;
        bus.Sample_in = '0;
        #1;
        model_clear();
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b1;
        cycle(1'b0, 6'd0);
    endtask

    task automatic test_reset();
        bus.sample_valid = 1'b0;
        bus.Sample_in = '0;
        #12;
        tests_run++;
        if (bus.FIR_out !== 15'd0) begin
            tests_failed++;
            $display("FAIL reset_fir_out got=%0d exp=0", bus.FIR_out);
        end
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid);
        end
        tests_run++;
        if (bus.filled !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_filled got=%0b exp=0", bus.filled);
        end
        release_reset();
    endtask

    task automatic test_impulse(input string tag);
        int imp [6] = '{3, 7, 20, 7, 3, 0};
        int idx = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(i <= 5, (i == 0) ? 6'd1 : 6'd0);
            tests_run++;
            if (bus.out_valid !== exp_valid || bus.FIR_out !== 15'(exp_out)) begin
                tests_failed++;
                $display("FAIL %s_model cyc=%0d got=%0b/%0d exp=%0b/%0d",
                         tag, i, bus.out_valid, bus.FIR_out, exp_valid, exp_out);
            end
            if (bus.out_valid === 1'b1 && idx < 6) begin
                tests_run++;
                if (bus.FIR_out !== 15'(imp[idx])) begin
                    tests_failed++;
                    $display("FAIL %s_pulse idx=%0d got=%0d exp=%0d", tag, idx, bus.FIR_out, imp[idx]);
                end
                idx++;
            end
        end
        tests_run++;
        if (idx != 6) begin
            tests_failed++;
            $display("FAIL %s_pulse_count got=%0d exp=6", tag, idx);
        end
    endtask

    task automatic test_step();
        int stp [6] = '{189, 630, 1890, 2331, 2520, 2520};
        int idx = 0;
        assert_reset();
        release_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(i <= 5, 6'd63);
            tests_run++;
            if (bus.filled !== exp_filled) begin
                tests_failed++;
                $display("FAIL step_filled cyc=%0d got=%0b exp=%0b", i, bus.filled, exp_filled);
            end
            if (bus.out_valid === 1'b1 && idx < 6) begin
                tests_run++;
                if (bus.FIR_out !== 15'(stp[idx])) begin
                    tests_failed++;
                    $display("FAIL step_pulse idx=%0d got=%0d exp=%0d", idx, bus.FIR_out, stp[idx]);
                end
                idx++;
            end
        end
        tests_run++;
        if (idx != 6) begin
            tests_failed++;
            $display("FAIL step_pulse_count got=%0d exp=6", idx);
        end
    endtask

    task automatic test_gapped();
        int gimp [5] = '{3, 7, 20, 7, 3};
        int idx = 0;
        assert_reset();
        release_reset();
        for (int i = 0; i < 17; i++) begin
            logic v;
            v = (i % 3 == 0) && (i < 15);
            cycle(v, (i == 0) ? 6'd1 : 6'($urandom_range(0, 63) * (v ? 0 : 1)));
            tests_run++;
            if (bus.out_valid !== exp_valid || bus.FIR_out !== 15'(exp_out)) begin
                tests_failed++;
                $display("FAIL gap_model cyc=%0d got=%0b/%0d exp=%0b/%0d",
                         i, bus.out_valid, bus.FIR_out, exp_valid, exp_out);
            end
            if (bus.out_valid === 1'b1 && idx < 5) begin
                tests_run++;
                if (bus.FIR_out !== 15'(gimp[idx])) begin
                    tests_failed++;
                    $display("FAIL gap_pulse idx=%0d got=%0d exp=%0d", idx, bus.FIR_out, gimp[idx]);
                end
                idx++;
            end
        end
        tests_run++;
        if (idx != 5) begin
            tests_failed++;
            $display("FAIL gap_pulse_count got=%0d exp=5", idx);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 6'd63);
        tests_run++;
        if (bus.FIR_out !== 15'(exp_out) || exp_out == 0) begin
            tests_failed++;
            $display("FAIL midrst_pre got=%0d exp=%0d", bus.FIR_out, exp_out);
        end
        assert_reset();
        tests_run++;
        if (bus.FIR_out !== 15'd0 || bus.out_valid !== 1'b0 || bus.filled !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_async got=%0d/%0b/%0b exp=0/0/0",
                     bus.FIR_out, bus.out_valid, bus.filled);
        end
        release_reset();
        test_impulse("midrst_imp");
    endtask

    task automatic test_random();
        int accepted = 0;
        int pulses = 0;
        int bad = 0;
        for (int s = 0; s < 1000; s++) begin
            int gap = $urandom_range(0, 2);
            for (int g = 0; g <= gap; g++) begin
                logic v;
                v = (g == gap);
                cycle(v, 6'($urandom_range(0, 63)));
                if (v) accepted++;
                if (bus.out_valid === 1'b1) pulses++;
                tests_run++;
                if (bus.out_valid !== exp_valid || bus.FIR_out !== 15'(exp_out) ||
                    bus.filled !== exp_filled) begin
                    tests_failed++;
                    if (bad < 10)
                        $display("FAIL rand s=%0d got=%0b/%0d/%0b exp=%0b/%0d/%0b", s,
                                 bus.out_valid, bus.FIR_out, bus.filled,
                                 exp_valid, exp_out, exp_filled);
                    bad++;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 6'd0);
            if (bus.out_valid === 1'b1) pulses++;
        end
        tests_run++;
        if (pulses != accepted) begin
            tests_failed++;
            $display("FAIL rand_pulse_count got=%0d exp=%0d", pulses, accepted);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sample_valid = 1'b0;
        bus.Sample_in = '0;
        test_reset();
        test_impulse("impulse");
        test_step();
        test_gapped();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/transposed_fir.md
TRANSPOSED_FIR -- requirements
Module: transposed_fir

Interface
REQ-001 Parameter FIR_order, default 4: filter order, giving FIR_order+1 taps.
REQ-002 Parameter Sample_size, default 6: unsigned input sample width, max 63.
REQ-003 Parameter weight_size, default 5: unsigned coefficient width, max 31.
REQ-004 Parameter word_size_out, default 2*Sample_size+3 (15): output width.
REQ-005 Parameters b0..b4, defaults 3, 7, 20, 7, 3: tap coefficients, weight_size bits each.
REQ-006 Port clock, input, 1: single clock; all state changes on its rising edge.
REQ-007 Port reset, input, 1: asynchronous, active-low reset.
REQ-008 Port Sample_in, input, Sample_size: unsigned sample x[n].
REQ-009 Port sample_valid, input, 1: Sample_in is valid this cycle.
REQ-010 Port FIR_out, output reg, word_size_out: filtered result y[n].
REQ-011 Port out_valid, output reg, 1: FIR_out holds a new result this cycle.
REQ-012 Port filled, output reg, 1: at least FIR_order+1 samples accepted since reset.

Function
REQ-013 Form SHALL be transposed direct form: every tap multiplies the current accepted sample, and the delay line sits in the adder chain, with data flowing from tap 4 toward tap 0.
REQ-014 Stage 1 SHALL capture M[k] <= b_k*Sample_in for k=0..4 on an edge where sample_valid=1, with prod_valid <= sample_valid on every edge.
REQ-015 Stage 2, on an edge where prod_valid=1, SHALL update S[4] <= M[4] and S[k] <= M[k]+S[k+1] for k=1..3, and FIR_out <= M[0]+S[1].
REQ-016 out_valid SHALL equal prod_valid delayed one edge, so a sample accepted at edge t yields FIR_out and out_valid=1 after edge t+2.
REQ-017 Result SHALL equal y[n]=sum over k of b_k*x[n-k], where n counts accepted samples only; samples not yet received count as 0.
REQ-018 With sample_valid=0, M SHALL hold; with prod_valid=0, S and FIR_out SHALL hold. Gaps SHALL NOT insert zero samples.
REQ-019 out_valid SHALL be a single-cycle pulse per accepted sample; back-to-back valid inputs SHALL give back-to-back out_valid pulses, one result per cycle.
REQ-020 Arithmetic SHALL be unsigned. Products SHALL be Sample_size+weight_size bits, and sums SHALL be zero-extended to word_size_out, so the full-scale value 2520 never overflows.
REQ-021 A 3-bit fill counter SHALL increment on each accepted sample and saturate at FIR_order+1; filled SHALL be 1 when it is saturated.

Reset
REQ-022 reset=0 SHALL immediately, without a clock, clear M, S, prod_valid, FIR_out, out_valid, the fill counter and filled.
REQ-023 Reset mid-stream SHALL discard all in-flight samples; output after release SHALL be as if no prior samples existed.
REQ-024 Samples SHALL NOT be accepted on the edge where reset deasserts if recovery timing is violated; the bench drives sample_valid=0 for one cycle after release.

Structure
REQ-025 A shared package SHALL hold FIR_order, Sample_size, weight_size, word_size_out and the default coefficients b0..b4.
REQ-026 Sub-module fir_tap SHALL implement one tap (product register plus adder and partial-sum register), instantiated FIR_order+1 times via generate; tap 4 adds zero.
REQ-027 Control (prod_valid, out_valid, fill counter) SHALL be in the top level.

Verification
REQ-028 Impulse: accept 1 then zeros (valid every cycle) -> FIR_out 3, 7, 20, 7, 3, 0 on consecutive out_valid pulses, first pulse 2 edges after the sample is accepted.
REQ-029 Step: accept 63 continuously -> 189, 630, 1890, 2331, 2520, 2520...; filled rises on the 5th accepted sample.
REQ-030 Gapped input: impulse sequence with sample_valid toggling 1,0,0,1,... -> identical values 3, 7, 20, 7, 3, with out_valid only 2 edges after each valid sample and FIR_out held between pulses.
REQ-031 Reset mid-stream: assert reset while S is non-zero -> all outputs 0 asynchronously; a new impulse after release gives 3, 7, 20, 7, 3.
REQ-032 Random: 1000 random samples with random valid gaps, checked against a reference model of y[n]; out_valid pulse count equals accepted sample count.
